// File: rtl/mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mm_pkg : shared types, block-count helper and BRAM image offsets           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4
  } mm_ctrl_state_t;

  function automatic int num_blocks(input int width);
    return (width + 1) / 17 + 1;
  endfunction

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_S     = num_blocks(DEFAULT_WIDTH);

  // Word offsets inside the BRAM operand image; the result lands on top of p'_0/p.
  localparam int OFS_PPRIME = 0;
  localparam int OFS_P      = 1;
  localparam int OFS_A      = OFS_P + DEFAULT_S;
  localparam int OFS_B      = OFS_P + 2 * DEFAULT_S;
  localparam int OFS_RES    = 0;

  function automatic int ofs_a(input int s);
    return OFS_P + s;
  endfunction

  function automatic int ofs_b(input int s);
    return OFS_P + 2 * s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_bram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mm_bram_ctrl : loads operands from BRAM, kicks FIOS, stores result back    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mm_bram_ctrl
  import mm_pkg::*;
#(
  parameter int  WIDTH = 256,
  localparam int S     = num_blocks(WIDTH)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  output logic            done_o,
  output logic            bram_en_o,
  output logic [3:0]      bram_we_o,
  output logic [31:0]     bram_addr_o,
  output logic [31:0]     bram_din_o,
  input  logic [31:0]     bram_dout_i,
  output logic [16:0]     p_prime_0_o,
  output logic [S*17-1:0] p_o,
  output logic [S*17-1:0] a_o,
  output logic [S*17-1:0] b_o,
  output logic            fios_start_o,
  input  logic            fios_done_i,
  input  logic [S*17-1:0] fios_res_i
);

  localparam int A0      = ofs_a(S);
  localparam int B0      = ofs_b(S);
  localparam int LAST_RD = 3 * S;
  localparam int CW      = $clog2(3 * S + 2) + 1;

  mm_ctrl_state_t  state, state_nx;
  logic [CW-1:0]   idx;
  logic            cap_vld;
  logic [CW-1:0]   cap_idx;
  logic [S*17-1:0] res_q;
  logic            unused_dout_hi;

  assign unused_dout_hi = ^bram_dout_i[31:17];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bram_en_o    = 1'b0;
    bram_we_o    = 4'h0;
    bram_addr_o  = '0;
    bram_din_o   = '0;
    fios_start_o = 1'b0;
    unique case (state)
      IDLE: if (start_i) state_nx = LOAD;
      LOAD: begin
        // The final LOAD cycle issues no read; it only drains the capture stage.
        if (idx <= CW'(LAST_RD)) begin
          bram_en_o   = 1'b1;
          bram_addr_o = 32'(idx) << 2;
        end
        if (idx == CW'(LAST_RD + 1)) state_nx = KICK;
      end
      KICK: begin
        fios_start_o = 1'b1;
        state_nx     = WAIT;
      end
      WAIT: if (fios_done_i) state_nx = STORE;
      STORE: begin
        bram_en_o   = 1'b1;
        bram_we_o   = 4'hF;
        bram_addr_o = (32'(OFS_RES) + 32'(idx)) << 2;
        bram_din_o  = {15'b0, res_q[17*idx +: 17]};
        if (idx == CW'(S - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      idx         <= '0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      p_prime_0_o <= '0;
      p_o         <= '0;
      a_o         <= '0;
      b_o         <= '0;
      res_q       <= '0;
      done_o      <= 1'b0;
    end else begin
      cap_vld <= (state == LOAD) && (idx <= CW'(LAST_RD));
      cap_idx <= idx;
      case (state)
        IDLE: begin
          if (start_i) begin
            done_o <= 1'b0;
            idx    <= '0;
          end
        end
        LOAD:  idx <= (idx == CW'(LAST_RD + 1)) ? '0 : idx + CW'(1);
        WAIT: begin
          if (fios_done_i) begin
            res_q <= fios_res_i;
            idx   <= '0;
          end
        end
        STORE: begin
          idx <= idx + CW'(1);
          if (idx == CW'(S - 1)) done_o <= 1'b1;
        end
        default: ;
      endcase
      // Read data arrives one cycle after its address; route it by the delayed index.
      if (cap_vld) begin
        if (cap_idx == CW'(OFS_PPRIME)) p_prime_0_o <= bram_dout_i[16:0];
        for (int i = 0; i < S; i++) begin
          if (cap_idx == CW'(OFS_P + i)) p_o[17*i +: 17] <= bram_dout_i[16:0];
          if (cap_idx == CW'(A0 + i))    a_o[17*i +: 17] <= bram_dout_i[16:0];
          if (cap_idx == CW'(B0 + i))    b_o[17*i +: 17] <= bram_dout_i[16:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_bram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mm_bram_ctrl : directed bench with BRAM model and hand-driven FIOS      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mm_bram_ctrl;

  localparam int S = 16;
  localparam int W = S * 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         done_o;
  logic         bram_en_o;
  logic [3:0]   bram_we_o;
  logic [31:0]  bram_addr_o;
  logic [31:0]  bram_din_o;
  logic [31:0]  bram_dout;
  logic [16:0]  p_prime_0_o;
  logic [W-1:0] p_o, a_o, b_o;
  logic         fios_start_o;
  logic         fios_done_i;
  logic [W-1:0] fios_res_i;

  logic [31:0]  mem [0:63];
  logic [63:0]  wr_mask;
  int           wr_cnt, bad_we, bad_din, bad_addr, kick_cnt;
  int           checks = 0;
  int           errors = 0;
  int           lat;
  logic [W-1:0] res_ones, res_seq, res_junk;

  always #5 clk = ~clk;

  mm_bram_ctrl #(.WIDTH(256)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start_i),
    .done_o       (done_o),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_din_o   (bram_din_o),
    .bram_dout_i  (bram_dout),
    .p_prime_0_o  (p_prime_0_o),
    .p_o          (p_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .fios_start_o (fios_start_o),
    .fios_done_i  (fios_done_i),
    .fios_res_i   (fios_res_i)
  );

  // Read-first BRAM with one cycle of read latency plus a write monitor
  always @(posedge clk) begin
    if (bram_en_o) begin
      int wi;
      wi = int'(bram_addr_o >> 2);
      if (wi > 63 || bram_addr_o[1:0] != 2'b00) begin
        bad_addr++;
      end else begin
        bram_dout <= mem[wi];
        if (bram_we_o != 4'h0) begin
          wr_cnt++;
          wr_mask[wi] = 1'b1;
          if (bram_we_o != 4'hF) bad_we++;
          if (bram_din_o[31:17] != 15'd0) bad_din++;
          for (int b = 0; b < 4; b++)
            if (bram_we_o[b]) mem[wi][8*b +: 8] = bram_din_o[8*b +: 8];
        end
      end
    end
  end

  always @(negedge clk) if (fios_start_o) kick_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pattern(input int k);
    return 32'((k << 10) | k);
  endfunction

  task automatic load_image(input logic [31:0] upper);
    mem[0] = upper | 32'h0001_ABCD;
    for (int k = 1; k < 64; k++) mem[k] = (k <= 3 * S) ? (upper | pattern(k)) : 32'd0;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; wr_mask = '0; bad_we = 0; bad_din = 0; bad_addr = 0;
  endtask

  task automatic wait_kick(input bit hold, input int spur, input int n0, output int n);
    n = n0;
    do begin
      tick();
      n++;
      if (!hold) start_i = 1'b0;
      fios_done_i = (spur != 0) && (n == spur);
    end while (!fios_start_o && n < 300);
    fios_done_i = 1'b0;
  endtask

  task automatic give_done(input logic [W-1:0] res);
    tick();
    fios_res_i  = res;
    fios_done_i = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
      fios_done_i = 1'b0;
    end while (!done_o && n < 100);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; fios_done_i = 1'b0; fios_res_i = '0;
    kick_cnt = 0;
    clear_mon();
    load_image(32'd0);
    for (int i = 0; i < S; i++) begin
      res_ones[17*i +: 17] = 17'h1FFFF;
      res_seq[17*i +: 17]  = 17'h10000 | 17'(i * 'h111);
      res_junk[17*i +: 17] = 17'h15555;
    end
    repeat (3) tick();
    check("rst_done", done_o, 0);
    check("rst_en", bram_en_o, 0);
    check("rst_we", bram_we_o, 0);
    check("rst_addr", bram_addr_o, 0);
    check("rst_din", bram_din_o, 0);
    check("rst_kick", fios_start_o, 0);
    check("rst_pp0", p_prime_0_o, 0);
    rst = 1'b0;
    tick();

    // Operand load, kick latency and capture placement
    start_i = 1'b1;
    wait_kick(1'b0, 0, 0, lat);
    check("t1_kick_lat", lat, 51);
    tick();
    check("t1_kick_pulse", fios_start_o, 0);
    check("t1_en_wait", bram_en_o, 0);
    check("t1_pp0", p_prime_0_o, 17'h1ABCD);
    check("t1_p0", p_o[16:0], 17'h00401);
    check("t1_a0", a_o[16:0], 17'h04411);
    check("t1_a15", a_o[271:255], 17'h08020);
    check("t1_b15", b_o[271:255], 17'h0C030);

    // Result store
    give_done(res_ones);
    wait_done(lat);
    check("t2_done_lat", lat, 17);
    check("t2_wr_cnt", wr_cnt, 16);
    check("t2_wr_mask", wr_mask, 64'hFFFF);
    check("t2_mem0", mem[0], 32'h0001FFFF);
    check("t2_mem15", mem[15], 32'h0001FFFF);
    check("t2_mem16", mem[16], pattern(16));
    check("t2_bad_we", bad_we, 0);
    check("t2_bad_addr", bad_addr, 0);

    // Dirty upper BRAM bits
    load_image(32'hFFFE0000);
    clear_mon();
    tick();
    start_i = 1'b1;
    wait_kick(1'b0, 0, 0, lat);
    check("t3_kick_lat", lat, 51);
    check("t3_pp0", p_prime_0_o, 17'h1ABCD);
    check("t3_p7", p_o[17*7 +: 17], 17'h02008);
    check("t3_b0", b_o[16:0], 17'h08421);
    give_done(res_seq);
    wait_done(lat);
    check("t3_bad_din", bad_din, 0);
    check("t3_mem3", mem[3], 32'h00010333);
    check("t3_mem9", mem[9], 32'h00010999);

    // start_i held high across the whole transaction
    load_image(32'd0);
    clear_mon();
    tick();
    kick_cnt = 0;
    start_i = 1'b1;
    wait_kick(1'b1, 0, 0, lat);
    check("t4_kick_lat", lat, 51);
    give_done(res_ones);
    wait_done(lat);
    check("t4_done_lat", lat, 17);
    check("t4_kick_cnt", kick_cnt, 1);
    tick();
    check("t4_done_clr", done_o, 0);
    check("t4_relaunch_en", bram_en_o, 1);
    check("t4_relaunch_addr", bram_addr_o, 0);
    start_i = 1'b0;
    wait_kick(1'b0, 0, 1, lat);
    check("t4_kick_lat2", lat, 51);
    give_done(res_ones);
    wait_done(lat);
    check("t4_done_lat2", lat, 17);

    // Reset in the middle of STORE
    load_image(32'd0);
    clear_mon();
    tick();
    start_i = 1'b1;
    wait_kick(1'b0, 0, 0, lat);
    give_done(res_seq);
    tick();
    fios_done_i = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("t5_en", bram_en_o, 0);
    check("t5_we", bram_we_o, 0);
    check("t5_addr", bram_addr_o, 0);
    check("t5_done", done_o, 0);
    check("t5_pp0", p_prime_0_o, 0);
    check("t5_p0", p_o[16:0], 0);
    tick();
    check("t5_wr_mask", wr_mask, 64'h1F);
    check("t5_mem4", mem[4], 32'h00010444);
    check("t5_mem5", mem[5], pattern(5));
    rst = 1'b0;
    load_image(32'd0);
    clear_mon();
    tick();
    start_i = 1'b1;
    wait_kick(1'b0, 0, 0, lat);
    check("t5_kick_lat", lat, 51);
    check("t5_b15", b_o[271:255], 17'h0C030);
    give_done(res_seq);
    wait_done(lat);
    check("t5_done_lat", lat, 17);
    check("t5_wr_cnt", wr_cnt, 16);
    check("t5_mem15", mem[15], 32'h00010FFF);

    // Spurious FIOS done during LOAD
    load_image(32'd0);
    clear_mon();
    tick();
    fios_res_i = res_junk;
    start_i = 1'b1;
    wait_kick(1'b0, 10, 0, lat);
    check("t6_kick_lat", lat, 51);
    check("t6_no_wr", wr_cnt, 0);
    check("t6_pp0", p_prime_0_o, 17'h1ABCD);
    give_done(res_seq);
    wait_done(lat);
    check("t6_done_lat", lat, 17);
    check("t6_mem0", mem[0], 32'h00010000);
    check("t6_mem6", mem[6], 32'h00010666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
